uart_rx_monitor: RTL and testbench

//  Receives the 8N1 serial stream driven on uart_tx_wire by the data-memory UART transmitter.

---
 rtl/uart_rx_monitor.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
// 8N1 serial receiver for the UART TX console stream: 2-flop synchronizer, mid-bit sampling FSM,
// and a single holding register presented on a valid/ready interface.
module uart_rx_monitor #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 rx_s;

    state_t               state_q,     state_d;
    logic [CNT_W-1:0]     clk_cnt_q,   clk_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q,   bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic                 deliver_q,   deliver_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 rx_valid_q,  rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q,   overrun_d;
    logic                 busy_q,      busy_d;

    assign rx_s = sync2_q;

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        deliver_d   = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d   = S_START;
                    clk_cnt_d = '0;
                end
            end

            S_START: begin
                if (clk_cnt_q == HALF) begin
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        state_d   = S_IDLE;
                        deliver_d = 1'b1;
                    end else begin
                        state_d     = S_BREAK;
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            // A held-low line must return high before another start can be detected.
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Delivery runs one cycle after the stop sample; a same-cycle consume frees the slot.
        if (deliver_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            deliver_q   <= deliver_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor at 16 clk/bit: one task per scenario with inline checks.
module tb_uart_rx_monitor;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int         cyc       = 0;
    int         fe_cnt    = 0;
    int         ov_cnt    = 0;
    int         both_cnt  = 0;
    int         rise_cnt  = 0;
    int         rise_cyc  = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] hs_q[$];

    uart_rx_monitor #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Observes outputs mid-cycle, after the drivers have settled inputs for the next edge.
    always @(negedge clk) begin
        #1;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
        if (rx_valid && !prev_valid) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        prev_valid = rx_valid;
        if (rx_valid && rx_ready) hs_q.push_back(rx_data);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            wait_clks(CPB);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
        wait_clks(3);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL reset_pulses got fe=%b ov=%b exp 0 0", frame_err, overrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        wait_clks(20);
    endtask

    task automatic test_basic_byte();
        int fe0, ov0, r0, start_cyc, lat;
        fe0 = fe_cnt; ov0 = ov_cnt; r0 = rise_cnt;
        rx_ready = 1'b0;
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        wait_clks(2);
        lat = rise_cyc - start_cyc;
        total++; if (rise_cnt - r0 !== 1) begin bad++; $display("FAIL t1_rises got=%0d exp=1", rise_cnt - r0); end
        total++; if (lat < 150 || lat > 165) begin bad++; $display("FAIL t1_latency got=%0d exp=150..165", lat); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL t1_valid got=%b exp=1", rx_valid); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL t1_data got=%h exp=a5", rx_data); end
        wait_clks(30);
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin bad++; $display("FAIL t1_hold got v=%b d=%h exp v=1 d=a5", rx_valid, rx_data); end
        total++; if (fe_cnt != fe0 || ov_cnt != ov0) begin bad++; $display("FAIL t1_errs got fe=%0d ov=%0d exp 0 0", fe_cnt - fe0, ov_cnt - ov0); end
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        wait_clks(1);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL t1_consume got=%b exp=0", rx_valid); end
        wait_clks(10);
    endtask

    task automatic test_glitch();
        int fe0, r0;
        fe0 = fe_cnt; r0 = rise_cnt;
        rx = 1'b0;
        wait_clks(4);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t2_busy_start got=%b exp=1", busy); end
        rx = 1'b1;
        wait_clks(10);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_busy_idle got=%b exp=0", busy); end
        wait_clks(200);
        total++; if (rise_cnt != r0 || rx_valid !== 1'b0) begin bad++; $display("FAIL t2_no_valid got rises=%0d v=%b exp 0 0", rise_cnt - r0, rx_valid); end
        total++; if (fe_cnt != fe0) begin bad++; $display("FAIL t2_no_fe got=%0d exp=0", fe_cnt - fe0); end
    endtask

    task automatic test_frame_error();
        int fe0, r0;
        fe0 = fe_cnt; r0 = rise_cnt;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        wait_clks(40);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t3_break_busy got=%b exp=1", busy); end
        rx = 1'b1;
        wait_clks(10);
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL t3_fe_count got=%0d exp=1", fe_cnt - fe0); end
        total++; if (rise_cnt != r0 || rx_valid !== 1'b0) begin bad++; $display("FAIL t3_no_valid got rises=%0d v=%b exp 0 0", rise_cnt - r0, rx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_idle got=%b exp=0", busy); end
        wait_clks(200);
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL t3_fe_final got=%0d exp=1", fe_cnt - fe0); end
    endtask

    task automatic test_overrun();
        int ov0;
        ov0 = ov_cnt;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clks(5);
        total++; if (ov_cnt - ov0 !== 1) begin bad++; $display("FAIL t4_overrun got=%0d exp=1", ov_cnt - ov0); end
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin bad++; $display("FAIL t4_keep got v=%b d=%h exp v=1 d=11", rx_valid, rx_data); end
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        wait_clks(1);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL t4_consume got=%b exp=0", rx_valid); end
        wait_clks(10);
    endtask

    task automatic test_back_to_back();
        int ov0, r0;
        ov0 = ov_cnt; r0 = rise_cnt;
        hs_q.delete();
        rx_ready = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clks(5);
        total++; if (hs_q.size() !== 2) begin bad++; $display("FAIL t5_count got=%0d exp=2", hs_q.size()); end
        if (hs_q.size() >= 2) begin
            total++; if (hs_q[0] !== 8'h00) begin bad++; $display("FAIL t5_first got=%h exp=00", hs_q[0]); end
            total++; if (hs_q[1] !== 8'hFF) begin bad++; $display("FAIL t5_second got=%h exp=ff", hs_q[1]); end
        end
        total++; if (rise_cnt - r0 !== 2) begin bad++; $display("FAIL t5_pulses got=%0d exp=2", rise_cnt - r0); end
        total++; if (ov_cnt != ov0 || rx_valid !== 1'b0) begin bad++; $display("FAIL t5_clean got ov=%0d v=%b exp 0 0", ov_cnt - ov0, rx_valid); end
        rx_ready = 1'b0;
        wait_clks(10);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] partial;
        int fe0;
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b1);
        wait_clks(3);
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'h77) begin bad++; $display("FAIL t6_held got v=%b d=%h exp v=1 d=77", rx_valid, rx_data); end
        partial = 8'h5A;
        rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = partial[i];
            wait_clks(CPB);
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t6_busy_pre got=%b exp=1", busy); end
        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        total++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin bad++; $display("FAIL t6_after_rst got busy=%b v=%b exp 0 0", busy, rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL t6_data_clr got=%h exp=00", rx_data); end
        wait_clks(20);
        fe0 = fe_cnt;
        send_frame(8'hC3, 1'b1);
        wait_clks(3);
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin bad++; $display("FAIL t6_resume got v=%b d=%h exp v=1 d=c3", rx_valid, rx_data); end
        total++; if (fe_cnt != fe0) begin bad++; $display("FAIL t6_no_fe got=%0d exp=0", fe_cnt - fe0); end
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
        test_reset();
        test_basic_byte();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        total++; if (both_cnt != 0) begin bad++; $display("FAIL fe_ov_together got=%0d exp=0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
